// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types and parameter defaults for the multiport register file
package rf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DUMP,
    DONE,
    HALTED
  } rf_dump_state_e;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 4;
  localparam int RF_NUM_RD = 2;

endpackage

// File: rtl/rf_dump_fsm.sv
// rtl/rf_dump_fsm.sv - halt-triggered dump sequencer: walks every register out over valid/ready
module rf_dump_fsm
  import rf_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hlt,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              dump_done,
  output logic              wr_block
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  rf_dump_state_e    state_d, state_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              valid_d, valid_q;
  logic              done_d, done_q;
  logic              hlt_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (hlt && !hlt_q) begin
          state_d = DUMP;
          addr_d  = (ZERO_REG != 0) ? ADDR_W'(1) : '0;
          valid_d = 1'b1;
        end
      end
      DUMP: begin
        if (dump_ready) begin
          if (addr_q == LAST_ADDR) begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      DONE:    state_d = HALTED;
      HALTED:  if (!hlt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      hlt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      hlt_q   <= hlt;
    end
  end

  // The array is frozen while entries are in flight so the dump is a consistent snapshot.
  assign wr_block   = (state_q == DUMP) || (state_q == DONE);
  assign dump_valid = valid_q;
  assign dump_addr  = addr_q;
  assign dump_done  = done_q;

endmodule

// File: rtl/rf_multiport.sv
// rtl/rf_multiport.sv - register file with NUM_RD registered read ports, one write port and dump port
module rf_multiport
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     hlt,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [ADDR_W-1:0]        dump_addr,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     dump_done
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_block;
  logic              wr_acc;

  rf_dump_fsm #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_dump_fsm (
    .clk       (clk),
    .rst       (rst),
    .hlt       (hlt),
    .dump_ready(dump_ready),
    .dump_valid(dump_valid),
    .dump_addr (dump_addr),
    .dump_done (dump_done),
    .wr_block  (wr_block)
  );

  assign wr_acc = wr_en && !wr_block && !((ZERO_REG != 0) && (wr_addr == '0));

  always_comb begin
    mem_d = mem_q;
    if (wr_acc) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) mem_q[j] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Writes are frozen during the dump, so a direct array read stays stable under backpressure.
  assign dump_data = dump_valid ? mem_q[dump_addr] : '0;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rd_d, rd_q;

    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      rd_d = rd_q;
      if (rd_en[i]) begin
        if ((ZERO_REG != 0) && (addr == '0))             rd_d = '0;
        else if ((BYPASS != 0) && wr_acc && (wr_addr == addr)) rd_d = wr_data;
        else                                             rd_d = mem_q[addr];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) rd_q <= '0;
      else     rd_q <= rd_d;
    end

    assign rd_data[i*DATA_W +: DATA_W] = rd_q;
  end

endmodule

// File: tb/tb_rf_multiport.sv
// tb/tb_rf_multiport.sv - directed vector bench for rf_multiport (bypass and no-bypass instances)
module tb_rf_multiport;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_en;
  logic [7:0]  rd_addr;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        hlt;
  logic        dump_ready;

  logic [31:0] rd_data,  nb_rd_data;
  logic        dump_valid, nb_dump_valid;
  logic [3:0]  dump_addr,  nb_dump_addr;
  logic [15:0] dump_data,  nb_dump_data;
  logic        dump_done,  nb_dump_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_multiport dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .hlt(hlt),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
    .dump_data(dump_data), .dump_done(dump_done)
  );

  rf_multiport #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(nb_rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .hlt(hlt),
    .dump_valid(nb_dump_valid), .dump_ready(dump_ready), .dump_addr(nb_dump_addr),
    .dump_data(nb_dump_data), .dump_done(nb_dump_done)
  );

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [1:0]  re;
    logic [3:0]  a0;
    logic [3:0]  a1;
    logic [15:0] e0;
    logic [15:0] e1;
    logic [15:0] n0;
    logic [15:0] n1;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0]  exp_addr;
    logic [3:0]  stall_addr;
    logic        stall_pending;
    int          ndone;
    bit          finished;

    rst = 1'b1; rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    hlt = 1'b0; dump_ready = 1'b0;

    vecs[0]  = '{1'b1, 4'd5, 16'hBEEF, 2'b11, 4'd1, 4'd2, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 4'd0, 16'h0000, 2'b11, 4'd5, 4'd5, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF};
    vecs[2]  = '{1'b1, 4'd0, 16'h1234, 2'b11, 4'd0, 4'd5, 16'h0000, 16'hBEEF, 16'h0000, 16'hBEEF};
    vecs[3]  = '{1'b0, 4'd0, 16'h0000, 2'b11, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[4]  = '{1'b1, 4'd7, 16'hA5A5, 2'b11, 4'd7, 4'd3, 16'hA5A5, 16'h0000, 16'h0000, 16'h0000};
    vecs[5]  = '{1'b1, 4'd7, 16'h1111, 2'b01, 4'd7, 4'd7, 16'h1111, 16'h0000, 16'hA5A5, 16'h0000};
    vecs[6]  = '{1'b1, 4'd7, 16'h2222, 2'b00, 4'd7, 4'd7, 16'h1111, 16'h0000, 16'hA5A5, 16'h0000};
    vecs[7]  = '{1'b1, 4'd7, 16'h3333, 2'b00, 4'd7, 4'd7, 16'h1111, 16'h0000, 16'hA5A5, 16'h0000};
    vecs[8]  = '{1'b1, 4'd7, 16'h4444, 2'b00, 4'd7, 4'd7, 16'h1111, 16'h0000, 16'hA5A5, 16'h0000};
    vecs[9]  = '{1'b0, 4'd0, 16'h0000, 2'b11, 4'd7, 4'd7, 16'h4444, 16'h4444, 16'h4444, 16'h4444};
    vecs[10] = '{1'b1, 4'd0, 16'hFFFF, 2'b11, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

    cyc(); cyc();
    check("reset_rd_data", rd_data, 32'h0);
    check("reset_dump_valid", {31'h0, dump_valid}, 32'h0);
    check("reset_dump_addr", {28'h0, dump_addr}, 32'h0);
    check("reset_dump_data", {16'h0, dump_data}, 32'h0);
    check("reset_dump_done", {31'h0, dump_done}, 32'h0);
    rst = 1'b0;

    for (int a = 0; a < 16; a++) begin
      rd_en = 2'b11;
      rd_addr = {4'(15 - a), 4'(a)};
      cyc();
      check("reset_read_all", rd_data, 32'h0);
    end

    for (int v = 0; v < 11; v++) begin
      wr_en = vecs[v].we; wr_addr = vecs[v].wa; wr_data = vecs[v].wd;
      rd_en = vecs[v].re; rd_addr = {vecs[v].a1, vecs[v].a0};
      cyc();
      check($sformatf("vec%0d_bypass", v), rd_data, {vecs[v].e1, vecs[v].e0});
      check($sformatf("vec%0d_nobypass", v), nb_rd_data, {vecs[v].n1, vecs[v].n0});
    end
    wr_en = 1'b0; rd_en = 2'b00;

    for (int i = 1; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'h1000 + 16'(i);
      cyc();
    end
    wr_en = 1'b0;

    hlt = 1'b1;
    cyc();
    check("dump_start_valid", {31'h0, dump_valid}, 32'h1);
    check("dump_start_addr", {28'h0, dump_addr}, 32'h1);
    exp_addr = 5'd1; ndone = 0; finished = 0; stall_pending = 0; stall_addr = '0;
    for (int k = 0; k < 200 && !finished; k++) begin
      dump_ready = (k % 2 == 0);
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hDEAD;
      check("dump_valid_during", {31'h0, dump_valid}, 32'h1);
      if (dump_valid && dump_ready) begin
        check("dump_addr_order", {28'h0, dump_addr}, {27'h0, exp_addr});
        check("dump_data", {16'h0, dump_data}, {16'h0, 16'h1000 + 16'(exp_addr)});
        exp_addr = exp_addr + 5'd1;
      end else begin
        stall_addr = dump_addr;
        stall_pending = 1;
      end
      cyc();
      if (stall_pending && !dump_done) begin
        check("dump_addr_stall_hold", {28'h0, dump_addr}, {28'h0, stall_addr});
      end
      stall_pending = 0;
      if (dump_done) begin
        ndone++;
        finished = 1;
      end
    end
    wr_en = 1'b0; dump_ready = 1'b0;
    check("dump_done_seen", {31'h0, 1'(finished)}, 32'h1);
    check("dump_transfer_count", {27'h0, exp_addr}, 32'd16);
    cyc();
    check("dump_done_one_cycle", {31'h0, dump_done}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("halted_no_redump", {30'h0, dump_valid, dump_done}, 32'h0);
    end
    rd_en = 2'b11; rd_addr = {4'd15, 4'd3};
    cyc();
    check("dump_writes_dropped", rd_data, {16'h100F, 16'h1003});
    rd_en = 2'b00;

    hlt = 1'b0; cyc(); cyc();
    hlt = 1'b1; dump_ready = 1'b1;
    cyc();
    for (int k = 0; k < 4; k++) begin
      check("partial_dump_addr", {28'h0, dump_addr}, 32'(k + 1));
      cyc();
    end
    rst = 1'b1; hlt = 1'b0; dump_ready = 1'b0;
    cyc();
    check("rst_mid_dump_valid", {31'h0, dump_valid}, 32'h0);
    check("rst_mid_dump_addr", {28'h0, dump_addr}, 32'h0);
    check("rst_mid_dump_done", {31'h0, dump_done}, 32'h0);
    rst = 1'b0;
    cyc();
    check("idle_after_rst", {31'h0, dump_valid}, 32'h0);
    hlt = 1'b1; dump_ready = 1'b1;
    cyc();
    exp_addr = 5'd1; ndone = 0; finished = 0;
    for (int k = 0; k < 100 && !finished; k++) begin
      if (dump_valid) begin
        check("redump_addr", {28'h0, dump_addr}, {27'h0, exp_addr});
        check("redump_data_zero", {16'h0, dump_data}, 32'h0);
        exp_addr = exp_addr + 5'd1;
      end
      cyc();
      if (dump_done) begin
        ndone++;
        finished = 1;
      end
    end
    check("redump_done_seen", {31'h0, 1'(finished)}, 32'h1);
    check("redump_count", {27'h0, exp_addr}, 32'd16);
    check("redump_done_pulses", 32'(ndone), 32'd1);
    hlt = 1'b0; dump_ready = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
